// File: rtl/pdm_mic_frontend.sv
// pdm_mic_frontend: PDM mic clock, sliding-window ones density, deviation and peak hold in clk_i domain
// Define PEAK_DECAY_EN to let peak_o decay by 1 every DECAY_SAMPLES valid samples.
module pdm_mic_frontend #(
   parameter int CLK_DIV = 50,
   parameter int WIN_LOG2 = 7
`ifdef PEAK_DECAY_EN
   , parameter int DECAY_SAMPLES = 1024
`endif
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   output logic                m_clk_o,
   output logic                m_lrsel_o,
   input  logic                m_data_i,
   input  logic                clear_i,
   output logic                sample_valid_o,
   output logic [WIN_LOG2:0]   density_o,
   output logic [WIN_LOG2-1:0] deviation_o,
   output logic [WIN_LOG2-1:0] peak_o
);
   localparam int WIN = 1 << WIN_LOG2;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [WIN_LOG2:0] MID = (WIN_LOG2+1)'(WIN / 2);
   localparam logic [WIN_LOG2:0] FULL = (WIN_LOG2+1)'(WIN);

   logic [DW-1:0]       div_cnt;
   logic [1:0]          sync;
   logic [WIN-1:0]      win;
   logic [WIN_LOG2:0]   dens, dens_next, fill;
   logic [WIN_LOG2-1:0] dev_next, peak_next;
   logic                div_wrap, sample_evt, full_next;

   assign m_lrsel_o = 1'b0;
   assign div_wrap = div_cnt == DW'(CLK_DIV - 1);
   assign sample_evt = div_wrap && !m_clk_o;
   assign full_next = fill >= FULL - (WIN_LOG2+1)'(1);
   assign dens_next = dens + (WIN_LOG2+1)'(sync[1]) - (WIN_LOG2+1)'(win[WIN-1]);
   assign dev_next = WIN_LOG2'(dens_next >= MID ? dens_next - MID : MID - dens_next);

`ifdef PEAK_DECAY_EN
   localparam int CW = $clog2(DECAY_SAMPLES + 1);
   logic [CW-1:0] decay_cnt;
   logic          decay;
   assign decay = decay_cnt == CW'(DECAY_SAMPLES - 1);
   assign peak_next = dev_next >= peak_o ? dev_next : decay ? peak_o - WIN_LOG2'(1) : peak_o;
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i)
         decay_cnt <= '0;
      else if (sample_evt && full_next)
         decay_cnt <= (dev_next >= peak_o || decay) ? '0 : decay_cnt + CW'(1);
   end
`else
   assign peak_next = dev_next > peak_o ? dev_next : peak_o;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_cnt <= '0;
         m_clk_o <= 1'b0;
         sync <= '0;
      end else begin
         div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
         m_clk_o <= m_clk_o ^ div_wrap;
         sync <= {sync[0], m_data_i};
      end
   end

   // clear has priority, so a coincident sample is dropped without a strobe
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         win <= '0;
         dens <= '0;
         fill <= '0;
         sample_valid_o <= 1'b0;
         density_o <= '0;
         deviation_o <= '0;
         peak_o <= '0;
      end else begin
         sample_valid_o <= sample_evt && full_next;
         if (sample_evt) begin
            win <= {win[WIN-2:0], sync[1]};
            dens <= dens_next;
            fill <= fill == FULL ? fill : fill + (WIN_LOG2+1)'(1);
            if (full_next) begin
               density_o <= dens_next;
               deviation_o <= dev_next;
               peak_o <= peak_next;
            end
         end
      end
   end
endmodule
